uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO and pacing stage directly upstream of the UART transmitter. Buffers CPU bytes and drives
//  the UART's send/DataOut pair. The UART has no ready/busy output, so this block times each frame
//  itself from the same baud value: it holds send for exactly one baud-clock period, then stays off
//  for a guard interval covering the 10-bit frame plus the send-low re-arm edge.
// PARAMETERS
//  DEPTH         16        FIFO entries; must be a power of 2
//  ADDR_W        4         log2(DEPTH)
//  CLK_DIV_NUM   13499000  numerator used by the UART baud divider (div = CLK_DIV_NUM/baud)
//  GUARD_PERIODS 12        baud-clock periods send stays low after each launch (>=12 required)
// PORTS
//  clk_xtal  in   1       system clock, shared with the UART
//  rst_n     in   1       asynchronous active-low reset
//  baud      in   24      baud setting, same value wired to the UART
//  wr_en     in   1       write strobe, one byte per cycle
//  wr_data   in   8       byte to enqueue
//  clr_ovf   in   1       clears the overflow flag
//  send      out  1       to UART send
//  DataOut   out  8       to UART DataOut
//  busy      out  1       1 while state != IDLE
//  full      out  1       level == DEPTH
//  empty     out  1       level == 0
//  level     out  ADDR_W+1 occupancy, 0..DEPTH
//  overflow  out  1       sticky; set when a write is dropped
// BEHAVIOUR
//  Reset (async, rst_n=0): send=0, DataOut=8'h00, busy=0, level=0, empty=1, full=0, overflow=0,
//   state=IDLE, pointers=0, timers=0. Reset mid-frame drops send at once and discards queued bytes.
//  FIFO: circular buffer, ADDR_W-bit rd/wr pointers that wrap at DEPTH; level is a separate counter.
//   - Write is accepted when !full, or when full and a pop happens in the same cycle.
//   - A write that is not accepted is dropped and sets overflow. clr_ovf clears overflow; if a drop
//     and clr_ovf happen in the same cycle, the set wins.
//   - Simultaneous push and pop leaves level unchanged.
//  Period: per = 2*(CLK_DIV_NUM/baud + 1) clk_xtal cycles, 32-bit unsigned. It is computed and
//   registered at launch and held for the whole frame; a baud change mid-frame does not affect it.
//  FSM:
//   IDLE: if !empty && baud!=0, pop the head, DataOut<=head, send<=1, timer<=per-1, go to SEND.
//         If baud==0, stay in IDLE: no launch, and queued bytes are retained.
//   SEND: decrement timer each cycle. At 0: send<=0, timer<=GUARD_PERIODS*per-1, go to GAP.
//         send is therefore high for exactly per cycles, which gives exactly one clk_baud posedge.
//   GAP:  decrement timer each cycle. At 0, go to IDLE. The next launch can occur on the following edge.
//  Timing:
//   - A write into an empty idle FIFO at edge N gives a pop and send=1 after edge N+1.
//   - Frame pitch for back-to-back bytes is per*(1+GUARD_PERIODS)+1 cycles.
//   - DataOut stays stable from launch until the next launch. It is never changed while send=1 or in GAP.
//  busy = (state!=IDLE). full, empty and level are registered and derived from the level counter.
// TESTING
//  T1 reset: rst_n=0 mid-SEND -> send=0 within the same cycle, level=0, empty=1, overflow=0, busy=0.
//  T2 single byte, baud=1349900 (div=10, per=22): write 8'hA5 -> send high 22 cycles starting 1 cycle after
//     the write, DataOut=8'hA5, GAP 264 cycles, busy low afterwards. A UART model serialises A5, LSB first.
//  T3 burst: write 8'h01..8'h03 on consecutive cycles -> send rising edges 287 cycles apart,
//     DataOut 01,02,03 in order, empty=1 after the third pop.
//  T4 full/overflow (DEPTH=16, baud=0 to stall): 17 writes -> level=16, full=1, overflow=1,
//     byte 17 dropped. clr_ovf -> overflow=0. Then set baud -> the 16 bytes drain in order.
//  T5 write while full with a simultaneous pop -> write accepted, level stays 16, overflow stays 0.
//  T6 baud changes 9600->1349900 during GAP -> the current frame keeps the old per,
//     the next launch uses per=22.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//  CPU-side bus of the UART transmit FIFO: byte write strobe plus the
//  status flags the CPU polls.
//  master : CPU / bench side (drives wr_en, wr_data, clr_ovf)
//  slave  : FIFO side (drives full, empty, level, overflow, busy)
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_ovf;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              busy;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  full, empty, level, overflow, busy
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output full, empty, level, overflow, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//  Byte FIFO and pacing stage in front of a UART transmitter that has no
//  busy output. Each frame is timed locally from the shared baud value:
//  send is held for one baud-clock period, then kept low for a guard
//  interval long enough for the 10-bit frame plus the send re-arm edge.
// Ports
//  clk_xtal  system clock, shared with the UART
//  rst_n     asynchronous active-low reset
//  baud      baud setting (same value the UART uses); 0 stalls launches
//  cpu       write strobe/data, clr_ovf in; full/empty/level/overflow/busy out
//  send      UART send strobe
//  DataOut   UART data byte, stable from one launch to the next
//
// state | meaning
// IDLE  | waiting for a queued byte and a non-zero baud
// SEND  | send high for one baud period (per cycles)
// GAP   | send low for GUARD_PERIODS*per cycles while the UART shifts
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int CLK_DIV_NUM   = 13499000,
  parameter int GUARD_PERIODS = 12
) (
  input  logic          clk_xtal,
  input  logic          rst_n,
  input  logic [23:0]   baud,
  uart_tx_fifo_if.slave cpu,
  output logic          send,
  output logic [7:0]    DataOut
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic [31:0]       timer;
  logic [31:0]       per_q;
  logic [31:0]       per_calc;
  logic              pop;
  logic              push;

  assign pop  = (state == IDLE) && !cpu.empty && (baud != 24'd0);
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push = cpu.wr_en && (!cpu.full || pop);

  // Two clk_xtal cycles per divider count, matching the UART's baud toggle.
  assign per_calc = ((32'(CLK_DIV_NUM) / {8'd0, baud}) + 32'd1) << 1;

  always_comb begin
    level_nxt = cpu.level;
    case ({push, pop})
      2'b10:   level_nxt = cpu.level + 1'b1;
      2'b01:   level_nxt = cpu.level - 1'b1;
      default: level_nxt = cpu.level;
    endcase
  end

  always_ff @(posedge clk_xtal) begin
    if (push) mem[wr_ptr] <= cpu.wr_data;
  end

  always_ff @(posedge clk_xtal or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cpu.level    <= '0;
      cpu.full     <= 1'b0;
      cpu.empty    <= 1'b1;
      cpu.overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cpu.level <= level_nxt;
      cpu.full  <= (level_nxt == (ADDR_W+1)'(DEPTH));
      cpu.empty <= (level_nxt == '0);
      // A dropped byte beats a simultaneous clear.
      if (cpu.wr_en && !push) cpu.overflow <= 1'b1;
      else if (cpu.clr_ovf)   cpu.overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_xtal or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      send     <= 1'b0;
      DataOut  <= 8'h00;
      timer    <= '0;
      per_q    <= '0;
      cpu.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            DataOut  <= mem[rd_ptr];
            send     <= 1'b1;
            per_q    <= per_calc;
            timer    <= per_calc - 32'd1;
            state    <= SEND;
            cpu.busy <= 1'b1;
          end
        end
        SEND: begin
          if (timer == 32'd0) begin
            send  <= 1'b0;
            timer <= 32'(GUARD_PERIODS) * per_q - 32'd1;
            state <= GAP;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        GAP: begin
          if (timer == 32'd0) begin
            state    <= IDLE;
            cpu.busy <= 1'b0;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: begin
          state    <= IDLE;
          send     <= 1'b0;
          cpu.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//  Directed bench for uart_tx_fifo: reset, single frame timing, burst pitch,
//  full/overflow, full write with simultaneous pop, mid-frame baud change.
module tb_uart_tx_fifo;

  localparam int PER_FAST   = 22;     // baud 1349900: div 10
  localparam int GAP_FAST   = 264;    // 12 * 22
  localparam int PITCH_FAST = 287;    // 22 * 13 + 1
  localparam int PER_SLOW   = 2814;   // baud 9600: div 1406
  localparam int GAP_SLOW   = 33768;  // 12 * 2814

  logic        clk_xtal;
  logic        rst_n;
  logic [23:0] baud;
  logic        send;
  logic [7:0]  DataOut;
  int          cyc;
  int          n_tests;
  int          n_fail;

  uart_tx_fifo_if #(.ADDR_W(4)) cpu_if ();

  uart_tx_fifo dut (
    .clk_xtal (clk_xtal),
    .rst_n    (rst_n),
    .baud     (baud),
    .cpu      (cpu_if),
    .send     (send),
    .DataOut  (DataOut)
  );

  initial clk_xtal = 1'b0;
  always #5 clk_xtal = ~clk_xtal;

  initial cyc = 0;
  always @(posedge clk_xtal) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_xtal);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    cpu_if.wr_en   = 1'b1;
    cpu_if.wr_data = b;
    step();
    cpu_if.wr_en   = 1'b0;
  endtask

  task automatic wait_launch(input string tag, input int limit);
    int n = 0;
    while (send === 1'b1 && n < limit) begin step(); n++; end
    while (send !== 1'b1 && n < limit) begin step(); n++; end
    check_val(tag, (n < limit), 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (cpu_if.busy !== 1'b0 && n < limit) begin step(); n++; end
    check_val(tag, (n < limit), 1'b1);
  endtask

  task automatic measure_high(input string tag, input logic [7:0] dout, output int n);
    int bad = 0;
    n = 0;
    while (send === 1'b1 && n < 100000) begin
      step();
      n++;
      if (DataOut !== dout) bad++;
    end
    check_val(tag, bad, 0);
  endtask

  task automatic measure_gap(input string tag, input logic [7:0] dout, output int n);
    int bad = 0;
    n = 0;
    while (cpu_if.busy === 1'b1 && n < 100000) begin
      step();
      n++;
      if (DataOut !== dout || send !== 1'b0) bad++;
    end
    check_val(tag, bad, 0);
  endtask

  initial begin
    int          n;
    int          t0;
    int          t1;
    int          bad;
    logic [9:0]  line;
    logic [7:0]  rx;
    logic [7:0]  exp_b;

    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    baud           = 24'd0;
    cpu_if.wr_en   = 1'b0;
    cpu_if.wr_data = 8'h00;
    cpu_if.clr_ovf = 1'b0;

    // reset state
    repeat (3) step();
    check_val("rst_send",     send,            1'b0);
    check_val("rst_dataout",  DataOut,         8'h00);
    check_val("rst_busy",     cpu_if.busy,     1'b0);
    check_val("rst_level",    cpu_if.level,    5'd0);
    check_val("rst_empty",    cpu_if.empty,    1'b1);
    check_val("rst_full",     cpu_if.full,     1'b0);
    check_val("rst_overflow", cpu_if.overflow, 1'b0);
    rst_n = 1'b1;
    repeat (2) step();

    // T2: single byte at per=22
    baud = 24'd1349900;
    push_byte(8'hA5);
    check_val("t2_send_at_wr", send,         1'b0);
    check_val("t2_level_wr",   cpu_if.level, 5'd1);
    step();
    check_val("t2_send_lat",   send,         1'b1);
    check_val("t2_dataout",    DataOut,      8'hA5);
    check_val("t2_busy",       cpu_if.busy,  1'b1);
    check_val("t2_empty_pop",  cpu_if.empty, 1'b1);
    // UART line model: start bit, 8 data bits LSB first, stop bit
    line = {1'b1, DataOut, 1'b0};
    rx   = 8'h00;
    for (int b = 1; b <= 8; b++) rx = {line[b], rx[7:1]};
    check_val("t2_uart_rx",    rx,           8'hA5);
    measure_high("t2_dout_stable_send", 8'hA5, n);
    check_val("t2_send_width", n, PER_FAST);
    measure_gap("t2_dout_stable_gap", 8'hA5, n);
    check_val("t2_gap_len",    n, GAP_FAST);
    check_val("t2_send_idle",  send, 1'b0);

    // T3: burst of three bytes
    cpu_if.wr_en   = 1'b1;
    cpu_if.wr_data = 8'h01;
    step();
    cpu_if.wr_data = 8'h02;
    step();
    check_val("t3_launch0", send,    1'b1);
    check_val("t3_dout0",   DataOut, 8'h01);
    t0 = cyc;
    cpu_if.wr_data = 8'h03;
    step();
    cpu_if.wr_en = 1'b0;
    wait_launch("t3_wait1", 400);
    t1 = cyc;
    check_val("t3_dout1",   DataOut, 8'h02);
    check_val("t3_pitch1",  t1 - t0, PITCH_FAST);
    wait_launch("t3_wait2", 400);
    t0 = cyc;
    check_val("t3_dout2",   DataOut, 8'h03);
    check_val("t3_pitch2",  t0 - t1, PITCH_FAST);
    check_val("t3_empty",   cpu_if.empty, 1'b1);
    wait_idle("t3_idle", 400);

    // T4: stall with baud=0, 17 writes
    baud = 24'd0;
    for (int i = 0; i < 17; i++) begin
      cpu_if.wr_en   = 1'b1;
      cpu_if.wr_data = 8'(8'h10 + i);
      step();
    end
    cpu_if.wr_en = 1'b0;
    check_val("t4_level",    cpu_if.level,    5'd16);
    check_val("t4_full",     cpu_if.full,     1'b1);
    check_val("t4_overflow", cpu_if.overflow, 1'b1);
    check_val("t4_empty",    cpu_if.empty,    1'b0);
    repeat (5) step();
    check_val("t4_stalled",  cpu_if.busy,     1'b0);
    cpu_if.clr_ovf = 1'b1;
    step();
    cpu_if.clr_ovf = 1'b0;
    check_val("t4_clr_ovf",  cpu_if.overflow, 1'b0);
    check_val("t4_level_kept", cpu_if.level,  5'd16);

    // T5: write while full on the same edge as the first pop
    baud           = 24'd1349900;
    cpu_if.wr_en   = 1'b1;
    cpu_if.wr_data = 8'h30;
    step();
    cpu_if.wr_en   = 1'b0;
    check_val("t5_level",    cpu_if.level,    5'd16);
    check_val("t5_full",     cpu_if.full,     1'b1);
    check_val("t5_overflow", cpu_if.overflow, 1'b0);
    check_val("t5_send",     send,            1'b1);
    check_val("t5_dout0",    DataOut,         8'h10);
    bad = 0;
    for (int i = 1; i < 17; i++) begin
      exp_b = (i < 16) ? 8'(8'h10 + i) : 8'h30;
      wait_launch("t4_drain_wait", 400);
      if (DataOut !== exp_b) begin
        bad++;
        $display("FAIL t4_drain_byte%0d: got 0x%0h required 0x%0h", i, DataOut, exp_b);
      end
    end
    check_val("t4_drain_order", bad, 0);
    check_val("t4_drain_empty", cpu_if.empty, 1'b1);
    check_val("t4_drain_level", cpu_if.level, 5'd0);
    wait_idle("t4_idle", 400);

    // T6: baud change 9600 -> 1349900 during GAP
    baud = 24'd9600;
    push_byte(8'h5A);
    step();
    check_val("t6_launch", send, 1'b1);
    measure_high("t6_dout_stable_send", 8'h5A, n);
    check_val("t6_send_width_old", n, PER_SLOW);
    n   = 0;
    bad = 0;
    while (cpu_if.busy === 1'b1 && n < 100000) begin
      if (n == 100) begin
        baud           = 24'd1349900;
        cpu_if.wr_en   = 1'b1;
        cpu_if.wr_data = 8'hC3;
      end else begin
        cpu_if.wr_en   = 1'b0;
      end
      step();
      n++;
      if (DataOut !== 8'h5A || send !== 1'b0) bad++;
    end
    cpu_if.wr_en = 1'b0;
    check_val("t6_gap_stable",   bad, 0);
    check_val("t6_gap_len_old",  n, GAP_SLOW);
    check_val("t6_no_early",     send, 1'b0);
    step();
    check_val("t6_launch2",      send, 1'b1);
    check_val("t6_dout2",        DataOut, 8'hC3);
    measure_high("t6_dout_stable_send2", 8'hC3, n);
    check_val("t6_send_width_new", n, PER_FAST);
    wait_idle("t6_idle", 400);

    // T1: reset mid-SEND with bytes still queued
    cpu_if.wr_en   = 1'b1;
    cpu_if.wr_data = 8'h11;
    step();
    cpu_if.wr_data = 8'h22;
    step();
    cpu_if.wr_data = 8'h33;
    step();
    cpu_if.wr_en   = 1'b0;
    check_val("t1_in_send",  send,         1'b1);
    check_val("t1_queued",   cpu_if.level, 5'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t1_send",     send,            1'b0);
    check_val("t1_level",    cpu_if.level,    5'd0);
    check_val("t1_empty",    cpu_if.empty,    1'b1);
    check_val("t1_overflow", cpu_if.overflow, 1'b0);
    check_val("t1_busy",     cpu_if.busy,     1'b0);
    check_val("t1_dataout",  DataOut,         8'h00);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (send !== 1'b0 || cpu_if.busy !== 1'b0) bad++;
    end
    check_val("t1_discarded", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
